// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux port among NUM_REQ requesters.
// Define RFARB_FIXED_PRIO_EN to switch to fixed priority (lowest index wins).
module regfile_read_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [ADDR_W-1:0]         o_rf_sel,
    input  logic [DATA_W-1:0]         i_rf_data,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    input  logic [NUM_REQ-1:0]        i_rsp_ready,
    output logic                      o_busy
);

    localparam int unsigned IdxW  = $clog2(NUM_REQ);
    localparam int unsigned CandW = IdxW + 1;

    typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;

    state_e          state_q;
    logic [IdxW-1:0] gnt_q;
    logic [IdxW-1:0] win_idx;
    logic            win_found;

`ifdef RFARB_FIXED_PRIO_EN
    // Descending scan so the lowest-index valid requester is the last write.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req_valid[i]) begin
                win_found = 1'b1;
                win_idx   = IdxW'(i);
            end
        end
    end
`else
    logic [IdxW-1:0]  last_q;
    logic [CandW-1:0] cand;

    // Search from last_q+1 wrapping at NUM_REQ; the sum never exceeds 2*NUM_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_q} + CandW'(i);
            if (cand >= CandW'(NUM_REQ)) begin
                cand = cand - CandW'(NUM_REQ);
            end
            if (!win_found && i_req_valid[cand[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IdxW-1:0];
            end
        end
    end
`endif

    always_comb begin
        o_req_ready = '0;
        if (state_q == StIdle && win_found) begin
            o_req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        o_rsp_valid = '0;
        if (state_q == StResp) begin
            o_rsp_valid[gnt_q] = 1'b1;
        end
    end

    assign o_busy = (state_q != StIdle);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            o_rf_sel   <= '0;
            o_rsp_data <= '0;
`ifndef RFARB_FIXED_PRIO_EN
            last_q     <= IdxW'(NUM_REQ - 1);
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        gnt_q    <= win_idx;
                        o_rf_sel <= i_req_addr[win_idx*ADDR_W +: ADDR_W];
`ifndef RFARB_FIXED_PRIO_EN
                        last_q   <= win_idx;
`endif
                        state_q  <= StRead;
                    end
                end
                StRead: begin
                    // x0 is hard-wired to zero regardless of what the mux returns.
                    o_rsp_data <= (o_rf_sel == '0) ? '0 : i_rf_data;
                    state_q    <= StResp;
                end
                StResp: begin
                    if (i_rsp_ready[gnt_q]) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a response scoreboard and a modelled read mux.
module tb_regfile_read_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [19:0] req_addr;
    logic [3:0]  req_ready;
    logic [4:0]  rf_sel;
    logic [31:0] rf_data;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_ready;
    logic        busy;

    logic        ov_en;
    logic [31:0] ov_val;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    regfile_read_arbiter dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .i_req_addr  (req_addr),
        .o_req_ready (req_ready),
        .o_rf_sel    (rf_sel),
        .i_rf_data   (rf_data),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .i_rsp_ready (rsp_ready),
        .o_busy      (busy)
    );

    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return {8'hC3, 3'b000, a, ~{3'b000, a}, 8'h5A};
    endfunction

    // Register-file read mux model, optionally overridden for the x0 test.
    assign rf_data = ov_en ? ov_val : rf_val(rf_sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(rsp_valid), 32'(4'b0001 << e.idx));
            chk({tag, "_data"}, rsp_data, e.data);
        end
    endtask

    task automatic set_addr(input int k, input logic [4:0] a);
        req_addr[k*5 +: 5] = a;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        int          exp_gnt;

        checks    = 0;
        errors    = 0;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = '0;
        ov_en     = 1'b0;
        ov_val    = '0;

        // Reset state
        do_reset();
        settle();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rf_sel", 32'(rf_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'(dut.gnt_q), 32'd0);
`ifndef RFARB_FIXED_PRIO_EN
        chk("rst_last", 32'(dut.last_q), 32'd3);
`endif

        // Single read: req0 addr 7, data DEADBEEF
        ov_en     = 1'b1;
        ov_val    = 32'hDEADBEEF;
        rsp_ready = 4'b1111;
        set_addr(0, 5'd7);
        req_valid = 4'b0001;
        settle();
        chk("single_c0_ready", 32'(req_ready), 32'h1);
        sb.push_back('{idx: 2'd0, data: 32'hDEADBEEF});
        tick();
        req_valid = '0;
        settle();
        chk("single_c1_sel", 32'(rf_sel), 32'd7);
        chk("single_c1_ready", 32'(req_ready), 32'd0);
        tick();
        settle();
        check_rsp("single_c2");
        tick();
        settle();
        chk("single_c3_busy", 32'(busy), 32'd0);
        ov_en = 1'b0;

        // Round-robin with all four requesters held valid
        do_reset();
        for (int k = 0; k < 4; k++) set_addr(k, 5'(k + 4));
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        for (int n = 0; n < 5; n++) begin
`ifdef RFARB_FIXED_PRIO_EN
            exp_gnt = 0;
`else
            exp_gnt = n % 4;
`endif
            settle();
            chk($sformatf("rr%0d_ready", n), 32'(req_ready), 32'(4'b0001 << exp_gnt));
            sb.push_back('{idx: 2'(exp_gnt), data: rf_val(5'(exp_gnt + 4))});
            tick();
            settle();
            chk($sformatf("rr%0d_sel", n), 32'(rf_sel), 32'(exp_gnt + 4));
            tick();
            settle();
            check_rsp($sformatf("rr%0d_rsp", n));
            tick();
        end
        req_valid = '0;

        // Backpressure on req2 while req1 waits; req1 then reads x0
        do_reset();
        set_addr(2, 5'd3);
        set_addr(1, 5'd0);
        rsp_ready = 4'b1011;
        req_valid = 4'b0100;
        settle();
        chk("bp_c0_ready", 32'(req_ready), 32'h4);
        sb.push_back('{idx: 2'd2, data: rf_val(5'd3)});
        tick();
        req_valid = 4'b0010;
        settle();
        chk("bp_c1_sel", 32'(rf_sel), 32'd3);
        tick();
        settle();
        held = rsp_data;
        check_rsp("bp_c2");
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                tick();
                settle();
            end
            chk($sformatf("bp_hold%0d_valid", c), 32'(rsp_valid), 32'h4);
            chk($sformatf("bp_hold%0d_data", c), rsp_data, rf_val(5'd3));
            chk($sformatf("bp_hold%0d_ready", c), 32'(req_ready), 32'd0);
        end
        tick();
        rsp_ready = 4'b1111;
        settle();
        chk("bp_rise_ready", 32'(req_ready), 32'd0);
        chk("bp_rise_data", rsp_data, held);
        ov_en  = 1'b1;
        ov_val = 32'hFFFFFFFF;
        tick();
        settle();
        chk("bp_req1_ready", 32'(req_ready), 32'h2);
        sb.push_back('{idx: 2'd1, data: 32'd0});
        tick();
        req_valid = '0;
        settle();
        chk("x0_sel", 32'(rf_sel), 32'd0);
        tick();
        settle();
        check_rsp("x0_rsp");
        tick();
        ov_en = 1'b0;

        // Reset pulsed during RESP
        set_addr(0, 5'd9);
        rsp_ready = 4'b0000;
        req_valid = 4'b0001;
        settle();
        chk("mid_c0_ready", 32'(req_ready), 32'h1);
        sb.push_back('{idx: 2'd0, data: rf_val(5'd9)});
        tick();
        req_valid = '0;
        tick();
        settle();
        check_rsp("mid_resp");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        chk("mid_rst_sel", 32'(rf_sel), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
`ifndef RFARB_FIXED_PRIO_EN
        chk("mid_rst_last", 32'(dut.last_q), 32'd3);
`endif
        rsp_ready = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            tick();
            settle();
            chk($sformatf("mid_post%0d_valid", c), 32'(rsp_valid), 32'd0);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
